// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - op codes, FSM states and op predicates for md_iter_unit
package md_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MADD  = 4'd7,
        MD_MADDU = 4'd8,
        MD_MSUB  = 4'd9,
        MD_MSUBU = 4'd10
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } md_state_e;

    function automatic logic is_mul_op(input logic [3:0] op);
        return op inside {MD_MULT, MD_MULTU, MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU};
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return op inside {MD_DIV, MD_DIVU};
    endfunction

    function automatic logic is_signed_op(input logic [3:0] op);
        return op inside {MD_MULT, MD_DIV, MD_MADD, MD_MSUB};
    endfunction

endpackage

// File: rtl/md_iter_unit_if.sv
// rtl/md_iter_unit_if.sv - issue/result bundle between E stage and md_iter_unit
interface md_iter_unit_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [3:0]       md_op;
    logic             flush;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, md_op, flush, a, b,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, md_op, flush, a, b,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/md_div_core.sv
// rtl/md_div_core.sv - unsigned restoring divider, one quotient bit per cycle, MSB first
module md_div_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             abort,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             finish
);
    localparam int CNTW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             ge;

    // finish marks the cycle whose closing edge performs the last iteration
    assign finish    = (cnt_q == CNTW'(1));
    assign quotient  = quo_q;
    assign remainder = rem_q;

    always_comb begin
        rem_d = rem_q;
        quo_d = quo_q;
        dvs_d = dvs_q;
        cnt_d = cnt_q;
        trial = {rem_q, quo_q[WIDTH-1]};
        diff  = trial - {1'b0, dvs_q};
        ge    = (trial >= {1'b0, dvs_q});
        if (load) begin
            rem_d = '0;
            quo_d = dividend;
            dvs_d = divisor;
            cnt_d = CNTW'(WIDTH);
        end else if (abort) begin
            cnt_d = '0;
        end else if (cnt_q != '0) begin
            rem_d = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], ge};
            cnt_d = cnt_q - CNTW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/md_iter_unit.sv
// rtl/md_iter_unit.sv - iterative multiply/divide/accumulate unit owning HI/LO
module md_iter_unit
    import md_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MUL_LAT  = 5,
    parameter int DIV_ITER = WIDTH
) (
    input  logic          clk,
    input  logic          reset,
    md_iter_unit_if.slave md
);
    localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    md_state_e          state_q, state_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [3:0]         op_q, op_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
    logic               dz_pend_q, dz_pend_d;
    logic               done_q, done_d, div_zero_q, div_zero_d;

    logic               busy, issue, sgn, div_load, div_abort, div_finish;
    logic [2*WIDTH-1:0] ext_a, ext_b, acc;
    logic [WIDTH-1:0]   abs_a, abs_b, quo, rem, quo_fix, rem_fix;

    assign busy        = (state_q != ST_IDLE);
    assign issue       = md.start && !busy && !md.flush;
    assign md.busy     = busy;
    assign md.done     = done_q;
    assign md.div_zero = div_zero_q;
    assign md.hi       = hi_q;
    assign md.lo       = lo_q;

    always_comb begin
        sgn     = is_signed_op(md.md_op);
        ext_a   = sgn ? {{WIDTH{md.a[WIDTH-1]}}, md.a} : {{WIDTH{1'b0}}, md.a};
        ext_b   = sgn ? {{WIDTH{md.b[WIDTH-1]}}, md.b} : {{WIDTH{1'b0}}, md.b};
        // |MIN| wraps to MIN, which is the correct unsigned magnitude
        abs_a   = (sgn && md.a[WIDTH-1]) ? -md.a : md.a;
        abs_b   = (sgn && md.b[WIDTH-1]) ? -md.b : md.b;
        quo_fix = neg_quo_q ? -quo : quo;
        rem_fix = neg_rem_q ? -rem : rem;
        case (op_q)
            MD_MADD, MD_MADDU: acc = {hi_q, lo_q} + prod_q;
            MD_MSUB, MD_MSUBU: acc = {hi_q, lo_q} - prod_q;
            default:           acc = prod_q;
        endcase
    end

    md_div_core #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .reset     (reset),
        .load      (div_load),
        .abort     (div_abort),
        .dividend  (abs_a),
        .divisor   (abs_b),
        .quotient  (quo),
        .remainder (rem),
        .finish    (div_finish)
    );

    always_comb begin
        state_d    = state_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        prod_d     = prod_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        dz_pend_d  = dz_pend_q;
        done_d     = 1'b0;
        div_zero_d = 1'b0;
        div_load   = 1'b0;
        div_abort  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (issue) begin
                    if (md.md_op == MD_MTHI) begin
                        hi_d = md.a;
                    end else if (md.md_op == MD_MTLO) begin
                        lo_d = md.a;
                    end else if (is_mul_op(md.md_op)) begin
                        state_d = ST_MUL;
                        op_d    = md.md_op;
                        prod_d  = ext_a * ext_b;
                        cnt_d   = CW'(MUL_LAT - 1);
                    end else if (is_div_op(md.md_op)) begin
                        op_d      = md.md_op;
                        neg_quo_d = sgn && (md.a[WIDTH-1] ^ md.b[WIDTH-1]);
                        neg_rem_d = sgn && md.a[WIDTH-1];
                        if (md.b == '0) begin
                            state_d   = ST_FIX;
                            dz_pend_d = 1'b1;
                        end else begin
                            state_d   = ST_DIV;
                            dz_pend_d = 1'b0;
                            div_load  = 1'b1;
                        end
                    end
                end
            end
            ST_MUL: begin
                if (md.flush) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    {hi_d, lo_d} = acc;
                    done_d       = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_DIV: begin
                if (md.flush) begin
                    div_abort = 1'b1;
                    state_d   = ST_IDLE;
                end else if (div_finish) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                if (!md.flush) begin
                    done_d = 1'b1;
                    if (dz_pend_q) begin
                        div_zero_d = 1'b1;
                    end else begin
                        lo_d = quo_fix;
                        hi_d = rem_fix;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            hi_q       <= '0;
            lo_q       <= '0;
            prod_q     <= '0;
            op_q       <= '0;
            cnt_q      <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            dz_pend_q  <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            prod_q     <= prod_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            dz_pend_q  <= dz_pend_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    a_no_start_while_busy: assert property (@(posedge clk) disable iff (!reset) !(md.start && busy));
    a_div_iter_fixed:      assert property (@(posedge clk) DIV_ITER == WIDTH);
endmodule

// File: tb/tb_md_iter_unit.sv
// tb/tb_md_iter_unit.sv - scoreboard bench for md_iter_unit against an arithmetic model
module tb_md_iter_unit;
    import md_pkg::*;

    localparam int W  = 32;
    localparam int ML = 5;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    md_iter_unit_if #(.WIDTH(W)) bus ();

    md_iter_unit #(.WIDTH(W), .MUL_LAT(ML)) dut (
        .clk   (clk),
        .reset (reset_n),
        .md    (bus.slave)
    );

    exp_t        sbq[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    int          run_len = 0;
    int          last_run = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the architectural {HI,LO} pair
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p, acc;
        logic [31:0] q, r;
        exp_t        e;
        bit          s;
        if (op == MD_MTHI) begin
            m_hi = a;
        end else if (op == MD_MTLO) begin
            m_lo = a;
        end else if (op inside {MD_MULT, MD_MULTU, MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU}) begin
            s   = op inside {MD_MULT, MD_MADD, MD_MSUB};
            ea  = s ? 64'($signed(a)) : {32'd0, a};
            eb  = s ? 64'($signed(b)) : {32'd0, b};
            p   = ea * eb;
            acc = {m_hi, m_lo};
            if (op inside {MD_MADD, MD_MADDU})      acc = acc + p;
            else if (op inside {MD_MSUB, MD_MSUBU}) acc = acc - p;
            else                                    acc = p;
            {m_hi, m_lo} = acc;
            e = '{m_hi, m_lo, 1'b0, ML};
            sbq.push_back(e);
        end else if (op inside {MD_DIV, MD_DIVU}) begin
            if (b == 32'd0) begin
                e = '{m_hi, m_lo, 1'b1, 1};
            end else begin
                if (op == MD_DIVU) begin
                    q = a / b;
                    r = a % b;
                end else if (b == 32'hFFFF_FFFF) begin
                    q = 32'd0 - a;
                    r = 32'd0;
                end else begin
                    q = 32'($signed(a) / $signed(b));
                    r = 32'($signed(a) % $signed(b));
                end
                m_lo = q;
                m_hi = r;
                e = '{m_hi, m_lo, 1'b0, W + 1};
            end
            sbq.push_back(e);
        end
    endtask

    // Monitor: measures each busy run and checks every done pulse against the queue
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.busy === 1'b1) begin
                run_len++;
            end else if (run_len != 0) begin
                last_run = run_len;
                run_len  = 0;
            end
            if (bus.done === 1'b1) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("hi", bus.hi, e.hi);
                    chk("lo", bus.lo, e.lo);
                    chk("div_zero", bus.div_zero, e.dz);
                    chk("busy_cycles", last_run, e.lat);
                end
            end else if (bus.div_zero === 1'b1) begin
                chk("div_zero_without_done", 64'd1, 64'd0);
            end
        end
    end

    task automatic wait_not_busy(input string name);
        int n = 0;
        while (bus.busy === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk(name, 64'd1, 64'd0);
    endtask

    // Drives one issue cycle; returns on the negedge after the issue edge
    task automatic issue_only(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic fl);
        @(negedge clk);
        wait_not_busy("idle_timeout");
        bus.start = 1'b1;
        bus.flush = fl;
        bus.md_op = op;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.md_op = 4'd0;
    endtask

    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        model(op, a, b);
        issue_only(op, a, b, 1'b0);
        if (is_mul_op(op) || is_div_op(op)) begin
            wait_not_busy("done_timeout");
        end else begin
            chk("reg_op_busy", bus.busy, 1'b0);
            chk("reg_op_hi", bus.hi, m_hi);
            chk("reg_op_lo", bus.lo, m_lo);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0]  op;
        logic [31:0] ra, rb;
        reset_n   = 1'b0;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.md_op = 4'd0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_div_zero", bus.div_zero, 1'b0);
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);
        reset_n = 1'b1;

        do_op(MD_MULT, 32'hFFFF_FFFE, 32'd3);
        do_op(MD_MTHI, 32'h1234_5678, 32'd0);
        do_op(MD_MTLO, 32'd0, 32'd0);
        do_op(MD_MADDU, 32'h0001_0000, 32'h0001_0000);
        chk("maddu_hi", bus.hi, 32'h1234_5679);
        do_op(MD_DIV, 32'hFFFF_FFF9, 32'd2);
        chk("div_lo", bus.lo, 32'hFFFF_FFFD);
        chk("div_hi", bus.hi, 32'hFFFF_FFFF);
        do_op(MD_MTHI, 32'd5, 32'd0);
        do_op(MD_MTLO, 32'd6, 32'd0);
        do_op(MD_DIVU, 32'd100, 32'd0);
        do_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op(MD_MSUB, 32'd7, 32'hFFFF_FFFD);

        // Flush on busy cycle 10 of a divide
        issue_only(MD_DIV, 32'd1000, 32'd7, 1'b0);
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush_busy", bus.busy, 1'b0);
        chk("flush_done", bus.done, 1'b0);
        chk("flush_hi", bus.hi, m_hi);
        chk("flush_lo", bus.lo, m_lo);
        repeat (3) @(negedge clk);
        issue_only(MD_MULT, 32'd9, 32'd9, 1'b1);
        chk("flush_issue_busy", bus.busy, 1'b0);
        issue_only(MD_MTHI, 32'hDEAD_BEEF, 32'd0, 1'b1);
        chk("flush_mthi_hi", bus.hi, m_hi);

        // Asynchronous reset on busy cycle 3 of a multiply
        issue_only(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("arst_busy", bus.busy, 1'b0);
        chk("arst_done", bus.done, 1'b0);
        chk("arst_div_zero", bus.div_zero, 1'b0);
        chk("arst_hi", bus.hi, 32'd0);
        chk("arst_lo", bus.lo, 32'd0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        reset_n = 1'b1;
        do_op(MD_MULTU, 32'd2, 32'd3);

        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
            do_op(op, ra, rb);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/md_iter_unit.md
Name: md_iter_unit

Overview:
- Parametrised multiply/divide unit for the E stage of the pipelined MIPS core; successor to the fixed-latency MD block.
- Adds configurable operand width and multiply latency.
- Adds a true iterative restoring divider, MADD/MADDU/MSUB/MSUBU accumulate ops, divide-by-zero reporting, and clean abort on pipeline flush (IRQ/eret).
- HI/LO are architectural state, written only on completion or MTHI/MTLO.

Parameters:
- WIDTH, 32, operand and HI/LO width (min 8, even).
- MUL_LAT, 5, busy cycles for multiply/accumulate ops (min 1).
- DIV_ITER, WIDTH, quotient bits per divide; fixed equal to WIDTH, exposed for assertion only.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- start  in  1  issue qualifier; op accepted only when start=1, busy=0, flush=0.
- md_op  in  4  operation code from md_pkg.
- flush  in  1  pipeline flush (IRQ or eret in M); cancels in-flight op, blocks same-cycle issue.
- a  in  WIDTH  rs operand.
- b  in  WIDTH  rt operand.
- busy  out  1  op in flight; hazard unit stalls D on md instructions while busy or start.
- done  out  1  one-cycle pulse on the cycle HI/LO take a mult/div/acc result.
- div_zero  out  1  one-cycle pulse, coincident with done, for DIV/DIVU with b=0.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (reset=0, async): state IDLE, hi=0, lo=0, busy=0, done=0, div_zero=0, counter=0.
- FSM states: IDLE, MUL, DIV, FIX.
- Issue, in IDLE, accepted:
  - MTHI: hi<=a at this edge, busy stays 0.
  - MTLO: lo<=a at this edge, busy stays 0.
  - MD_NONE: no effect.
- MULT, MULTU, MADD, MADDU, MSUB, MSUBU:
  - Latch operands; full 2*WIDTH product (signed or unsigned per op) computed into a staging register.
  - Go to MUL, busy=1 for exactly MUL_LAT cycles starting the cycle after issue.
  - On the edge ending the last busy cycle: {hi,lo} <= P (MULT/MULTU), {hi,lo}+P (MADD/MADDU), or {hi,lo}-P (MSUB/MSUBU). All arithmetic is modulo 2^(2*WIDTH).
  - done=1 the following cycle; return to IDLE.
- DIV, DIVU:
  - If b=0: one busy cycle; hi/lo unchanged; done=1 and div_zero=1 together.
  - Otherwise: latch |a| and |b| (signed) or raw values (unsigned); DIV state runs WIDTH restoring iterations, one quotient bit per cycle, MSB first.
  - FIX state is one cycle: negate quotient if operand signs differ; remainder takes the sign of a.
  - Write lo=quotient, hi=remainder; done=1.
  - Busy for WIDTH+1 cycles total (33 at default).
  - Signed MIN/-1: lo=MIN, hi=0, no trap.
- start while busy=1: ignored, no state change. This is a protocol violation and is asserted against in simulation.
- flush=1 while busy: return to IDLE at next edge; hi/lo unchanged; done and div_zero stay 0; busy=0 the cycle after.
- flush=1 with start=1 in IDLE: op ignored, including MTHI/MTLO.
- flush=1 on the completion edge: result is discarded.
- reset mid-operation: immediate return to reset values.
- Unknown md_op codes: treated as MD_NONE.

Decomposition:
- md_pkg holds:
  - op encodings: MD_NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MADD=7, MADDU=8, MSUB=9, MSUBU=10;
  - FSM state encoding;
  - helper predicates is_mul_op, is_div_op, is_signed_op.
- One sub-module, md_div_core: the restoring iteration datapath (shift register, partial remainder, counter). It takes a load strobe, dividend and divisor, and returns quotient, remainder and a finish strobe.
- FSM, multiplier and HI/LO registers stay in md_iter_unit.

Test Plan:
- MULT a=0xFFFFFFFE(-2), b=3, MUL_LAT=5 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA; done pulses once.
- MTHI a=0x12345678, then MADDU a=0x10000, b=0x10000 with lo=0 -> hi=0x12345679, lo=0x00000000 after 5 busy cycles.
- DIV a=-7 (0xFFFFFFF9), b=2 -> busy 33 cycles; lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1).
- DIVU a=100, b=0 with hi=5, lo=6 -> busy 1 cycle; done and div_zero pulse together; hi=5, lo=6 unchanged.
- DIV issued, flush asserted on busy cycle 10 -> busy low next cycle; hi/lo retain prior values; no done pulse. A MULT issued in the same cycle as a flush leaves busy=0.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF, reset asserted on busy cycle 3 -> all outputs 0 immediately; after release a new MULTU 2x3 gives hi=0, lo=6.
